// File: rtl/regfile_bram_mp.sv
// regfile_bram_mp: multi-read-port register file, one synchronous-read RAM copy per port, self-clearing after reset.
// Define REGFILE_BRAM_FWD_EN to compile in write-first forwarding; otherwise colliding reads are read-first.
module regfile_bram_mp #(
  parameter int WIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*AWIDTH-1:0] ra,
  output logic [NREAD*WIDTH-1:0]  rd,
  input  logic [AWIDTH-1:0]       wa,
  input  logic                    we,
  input  logic [WIDTH-1:0]        wd,
  output logic                    ready
);
  localparam int DEPTH = 1 << AWIDTH;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic accept, mem_we;
  logic [AWIDTH-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == INIT && cnt_q == '1) ? RUN : state_q;
    cnt_d   = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
  end
  // INIT borrows the write port to sweep zeros through every copy
  always_comb begin
    ready  = state_q == RUN;
    accept = ready && we && !(ZERO_REG != 0 && wa == '0);
    mem_we = !ready || accept;
    mem_wa = ready ? wa : cnt_q;
    mem_wd = ready ? wd : '0;
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [AWIDTH-1:0] rak;
    logic zero_q;
    assign rak = ra[k*AWIDTH +: AWIDTH];
    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      ram_q <= mem[rak];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) zero_q <= 1'b0;
      else zero_q <= ZERO_REG != 0 && rak == '0;
    end
`ifdef REGFILE_BRAM_FWD_EN
    logic fwd_q;
    logic [WIDTH-1:0] fwd_wd_q;
    always_ff @(posedge clk) begin
      if (!rst_n) fwd_q <= 1'b0;
      else fwd_q <= accept && wa == rak;
      fwd_wd_q <= wd;
    end
    assign rd[k*WIDTH +: WIDTH] = zero_q ? '0 : fwd_q ? fwd_wd_q : ram_q;
`else
    assign rd[k*WIDTH +: WIDTH] = zero_q ? '0 : ram_q;
`endif
  end
endmodule

// File: doc/regfile_bram_mp.md
REGFILE_BRAM_MP -- requirements
Module: regfile_bram_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter AWIDTH, default 5: address width; depth is 2^AWIDTH entries.
REQ-003 SHALL have parameter NREAD, default 2, legal range 1..4: number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 always reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port ra, input, NREAD*AWIDTH bits: read addresses, with port k in bits [k*AWIDTH +: AWIDTH].
REQ-008 SHALL have port rd, output, NREAD*WIDTH bits: read data, with port k in bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port wa, input, AWIDTH bits: write address.
REQ-010 SHALL have port we, input, 1 bit: write enable.
REQ-011 SHALL have port wd, input, WIDTH bits: write data.
REQ-012 SHALL have port ready, output, 1 bit: high once initialisation is complete.

Function
REQ-013 SHALL implement one synchronous-read RAM copy per read port, so all copies hold identical contents.
REQ-014 SHALL write every copy at wa with wd when a write is accepted.
REQ-015 SHALL use a dedicated write address, so a read port address is never muxed with wa and reads never stall on writes.
REQ-016 SHALL have a read latency of exactly 1 cycle: rd port k in cycle n+1 reflects ra port k sampled in cycle n.
REQ-017 SHALL hold rd stable while ra is unchanged and no write hits that address.
REQ-018 SHALL implement a two-state FSM with states INIT and RUN; reset enters INIT with the clear counter at 0.
REQ-019 In INIT, SHALL write 0 to entry counter in every copy each cycle and increment the counter.
REQ-020 SHALL leave INIT for RUN in the cycle after the counter reaches 2^AWIDTH-1; the counter wraps to 0.
REQ-021 SHALL hold ready low in INIT and drive it high in RUN; ready rises exactly 2^AWIDTH cycles after rst_n is released.
REQ-022 SHALL ignore we in INIT; no user write is queued or lost silently beyond that.
REQ-023 SHALL return undefined data on rd during INIT; consumers gate on ready.
REQ-024 SHALL accept a write in RUN when we=1, and when ZERO_REG=1 also wa!=0.
REQ-025 When ZERO_REG=1, SHALL register (ra==0) per port and force rd to 0 in the next cycle, regardless of RAM content or forwarding.
REQ-026 SHALL support several ports reading the same address in one cycle, each returning identical data.

Reset
REQ-027 While rst_n=0 at a clock edge, SHALL set the FSM to INIT, the clear counter to 0, ready to 0 and all forwarding/zero flags to 0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence; RAM contents are not otherwise guaranteed.

Configuration
REQ-029 SHALL use macro REGFILE_BRAM_FWD_EN to compile write-to-read forwarding in or out.
REQ-030 With REGFILE_BRAM_FWD_EN defined, SHALL register per port (accepted write && wa==ra) and wd; that port's next-cycle rd then equals the registered wd (write-first), and ZERO_REG still overrides.
REQ-031 Without REGFILE_BRAM_FWD_EN, SHALL have no forwarding logic; a same-cycle colliding read returns the old contents (read-first), and the new value is visible from the following read.

Verification
REQ-032 Release rst_n with AWIDTH=5 -> ready=0 for 32 cycles, then ready=1; every address on every port reads 0.
REQ-033 In RUN, write 0xDEADBEEF to address 7, then read address 7 on ports 0 and 1 in the next cycle -> both rd=0xDEADBEEF one cycle later.
REQ-034 Write 0x12345678 to address 9 while ra0=9 in the same cycle -> with REGFILE_BRAM_FWD_EN rd0=0x12345678 next cycle; without it rd0=previous value, then 0x12345678 on the next read.
REQ-035 ZERO_REG=1, write 0xFFFFFFFF to address 0, then read address 0 -> rd=0 on all ports, both same-cycle and later.
REQ-036 Assert rst_n=0 at INIT counter 10 after writing address 20 with 0xA5A5A5A5 in RUN -> counter restarts at 0, ready stays low for 32 cycles, and address 20 reads 0.
REQ-037 Drive we=1 to address 3 with 0x55 during INIT -> write ignored; address 3 reads 0 after ready.
